// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding APB master driven by a valid/ready command stream
//
// Converts one command at a time into an APB SETUP/ACCESS transfer and returns
// one response per command.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : ACCESS is aborted after TIMEOUT_CYCLES cycles without pready (rsp_err=1)
//   undefined : ACCESS waits indefinitely; rsp_err is constant 0
//
// Ports
//   pclk, rstn                          clock, synchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_write, cmd_addr, cmd_wdata      command fields
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_err                  response fields
//   paddr, pwdata, pwrite, psel,        APB request side (all registered)
//   penable
//   prdata, pready                      APB completion side from the slave
module apb_cmd_master #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The abort fires on the ACCESS cycle whose wait would bring the count to
    // TIMEOUT_CYCLES, so the compare is against one less than the limit.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge pclk) begin
        if (!rstn) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        pwrite <= cmd_write;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    // pready on the limit cycle takes priority over the abort.
                    if (pready) begin
                        rsp_rdata <= pwrite ? '0 : prdata;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef APB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (wait_cnt == LIMIT_M1) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master with a behavioural APB register slave
module tb_apb_cmd_master;

    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] paddr;
    logic [15:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [15:0] prdata = '0;
    logic        pready = 1'b0;

    always #5 pclk = ~pclk;

    apb_cmd_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;
    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
    } cmd_t;

    rsp_t        sb[$];
    cmd_t        issued[$];
    logic [15:0] model [0:7];
    logic [15:0] smem  [0:7];

    // Behavioural register slave: random wait states, ignores addresses above bit 2.
    int          forced_wait = -1;
    int          waits = 0;
    cmd_t        cur;
    always @(negedge pclk) begin
        if (psel && !penable) begin
            waits = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
            if (issued.size() == 0) begin
                chk("setup_unexpected", 32'(psel), 32'(0));
            end else begin
                cur = issued.pop_front();
                chk("setup_addr", 32'(paddr), 32'(cur.a));
                chk("setup_wdata", 32'(pwdata), 32'(cur.d));
                chk("setup_dir", 32'(pwrite), 32'(cur.w));
            end
            pready = 1'($urandom);
            prdata = 16'($urandom);
        end else if (psel && penable) begin
            chk("access_hold", {pwrite, paddr, pwdata}, {cur.w, cur.a, cur.d});
            if (waits == 0) begin
                pready = 1'b1;
                prdata = smem[paddr[2:0]];
            end else begin
                waits--;
                pready = 1'b0;
                prdata = 16'($urandom);
            end
        end else begin
            chk("penable_no_psel", 32'(penable), 32'(0));
            pready = 1'($urandom);
            prdata = 16'($urandom);
        end
    end

    always @(posedge pclk) begin
        if (rstn && psel && penable && pready && pwrite)
            smem[paddr[2:0]] <= pwdata;
    end

    // Response monitor: drives rsp_ready and pops the scoreboard on each handshake.
    int          rdy_mode = 1;
    logic        hold = 1'b0;
    logic        rdy_next;
    rsp_t        held;
    rsp_t        exp_r;
    always @(negedge pclk) begin
        if (hold) begin
            chk("rsp_hold_valid", 32'(rsp_valid), 32'(1));
            chk("rsp_hold_data", {rsp_err, rsp_rdata}, {held.err, held.rdata});
        end
        rdy_next  = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom);
        rsp_ready = rdy_next;
        hold      = 1'b0;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else if (rdy_next) begin
                exp_r = sb.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_r.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(exp_r.err));
            end else begin
                hold       = 1'b1;
                held.rdata = rsp_rdata;
                held.err   = rsp_err;
            end
        end
    end

    task automatic set_mode(input int m);
        @(posedge pclk);
        rdy_mode = m;
        @(negedge pclk);
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
    endtask

    // Called at a negedge with a command presented; returns at the negedge after acceptance.
    task automatic wait_accept(input logic abort);
        int   n = 0;
        cmd_t c;
        rsp_t r;
        while (!cmd_ready && n < 500) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'(1));
        end else begin
            c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
            issued.push_back(c);
            r.err   = abort;
            r.rdata = (c.w || abort) ? 16'h0 : model[c.a[2:0]];
            if (c.w && !abort) model[c.a[2:0]] = c.d;
            sb.push_back(r);
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = 16'($urandom);
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        issue(w, a, d);
        wait_accept(1'b0);
    endtask

    function automatic int count_access_start();
        return 0;
    endfunction

    task automatic count_access(output int n);
        n = count_access_start();
        @(negedge pclk);
        while (psel && penable && n < 200) begin
            n++;
            @(negedge pclk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0) && n < 500) begin
            @(negedge pclk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            model[i] = 16'h0;
            smem[i]  = 16'h0;
        end
        repeat (3) @(negedge pclk);
        chk("reset_outs", {psel, penable, pwrite, rsp_valid, rsp_err}, 32'(0));
        chk("reset_bus", {paddr, pwdata}, 32'(0));
        chk("reset_rdata", 32'(rsp_rdata), 32'(0));
        chk("reset_cmd_ready", 32'(cmd_ready), 32'(1));
        rstn = 1'b1;
        @(negedge pclk);

        // Zero-wait write latency: psel N+1, penable N+2, response N+3
        forced_wait = 0;
        issue(1'b1, 16'h0000, 16'hA5A5);
        wait_accept(1'b0);
        chk("t1_setup", {psel, penable}, 32'b10);
        @(negedge pclk);
        chk("t1_access", {psel, penable}, 32'b11);
        @(negedge pclk);
        chk("t1_rsp", {rsp_valid, rsp_err, psel, penable}, 32'b1000);
        chk("t1_rdata", 32'(rsp_rdata), 32'(0));
        chk("t1_q0", 32'(smem[0]), 32'hA5A5);
        drain();

        // Write then read back, and read of an unwritten register
        forced_wait = -1;
        send(1'b1, 16'h0001, 16'h1234);
        send(1'b0, 16'h0001, 16'hFFFF);
        send(1'b0, 16'h0003, 16'h0000);
        drain();

        // Three wait states stretch ACCESS to four cycles
        forced_wait = 3;
        send(1'b1, 16'h0005, 16'h5A5A);
        count_access(n);
        chk("t3_access_len", 32'(n), 32'(4));
        drain();

        // Backpressure: response held, second command waits for the handshake
        forced_wait = 0;
        set_mode(2);
        send(1'b0, 16'h0001, 16'h0);
        issue(1'b1, 16'h0002, 16'hBEEF);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge pclk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_cmd_blocked", {rsp_valid, cmd_ready}, 32'b10);
            @(negedge pclk);
        end
        set_mode(1);
        chk("t4_hs_cycle", 32'(cmd_ready), 32'(0));
        @(negedge pclk);
        chk("t4_after_hs", {rsp_valid, cmd_ready}, 32'b01);
        wait_accept(1'b0);
        drain();
        chk("t4_write_done", 32'(smem[2]), 32'hBEEF);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abort after TO ACCESS cycles
        forced_wait = 1000;
        issue(1'b0, 16'h0001, 16'h0);
        wait_accept(1'b1);
        count_access(n);
        chk("t5_timeout_len", 32'(n), 32'(TO));
        drain();
        // pready on the limit cycle completes normally
        forced_wait = TO - 1;
        send(1'b0, 16'h0001, 16'h0);
        count_access(n);
        chk("t5_limit_len", 32'(n), 32'(TO));
        drain();
        forced_wait = -1;
        send(1'b1, 16'h0006, 16'h7777);
        drain();
`endif

        // Randomized traffic with random wait states and backpressure
        forced_wait = -1;
        set_mode(0);
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            send(1'($urandom), {13'($urandom), 3'($urandom)}, 16'($urandom));
        end
        set_mode(1);
        drain();

        // Reset during ACCESS drops the transfer without a response
        forced_wait = 5;
        send(1'b0, 16'h0002, 16'h0);
        @(negedge pclk);
        chk("t6_in_access", {psel, penable}, 32'b11);
        rstn = 1'b0;
        @(negedge pclk);
        chk("t6_reset_outs", {psel, penable, pwrite, rsp_valid, rsp_err}, 32'(0));
        chk("t6_reset_bus", {paddr, pwdata, rsp_rdata}, 48'(0));
        sb.delete();
        issued.delete();
        rstn = 1'b1;
        @(negedge pclk);
        chk("t6_ready_after", {cmd_ready, rsp_valid}, 32'b10);
        repeat (8) @(negedge pclk);
        forced_wait = -1;
        send(1'b0, 16'h0002, 16'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "global timeout");
    end

endmodule
